// File: rtl/kamus_pkg.sv
// Shared CSR definitions for the kamus core: address map, access ops and fixed values.
// The decoder, EX stage and CSR file all import this package.
package kamus_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_MHARTID   = 12'hF14
  } csr_t;

  typedef enum logic [1:0] {
    CSR_W = 2'd0,
    CSR_S = 2'd1,
    CSR_C = 2'd2
  } csr_op_t;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  function automatic logic csr_is_ro(logic [11:0] addr);
    return (addr == CSR_MISA) || (addr == CSR_MHARTID);
  endfunction

endpackage

// File: rtl/kamus_csr_if.sv
// Bundle of the CSR access port and trap/retire events between the core pipeline and the CSR file.
interface kamus_csr_if;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;

  modport master (
    output csr_en, csr_addr, csr_op, csr_we, csr_wdata,
    output retire, trap, trap_cause, trap_pc, mret,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_en, csr_addr, csr_op, csr_we, csr_wdata,
    input  retire, trap, trap_cause, trap_pc, mret,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/kamus_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment in that cycle.
module kamus_csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (we_lo_i) begin
      count_d[31:0] = wdata_i;
    end else if (we_hi_i) begin
      count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/kamus_csr.sv
// Machine-mode CSR file: combinational read of the old value, read-modify-write at the edge,
// trap entry / mret handling of mstatus/mepc/mcause, and the mcycle/minstret counters.
module kamus_csr
  import kamus_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_en_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle, minstret;
  logic [31:0] old_val, wr_val;
  logic        implemented, wr_en, trap_block;

  always_comb begin
    implemented = 1'b1;
    old_val     = '0;
    case (csr_addr_i)
      CSR_MSTATUS:   old_val = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CSR_MISA:      old_val = MISA_VALUE;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:   old_val = HART_ID;
      default:       implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      CSR_W:   wr_val = csr_wdata_i;
      CSR_S:   wr_val = old_val | csr_wdata_i;
      CSR_C:   wr_val = old_val & ~csr_wdata_i;
      default: wr_val = old_val;
    endcase
  end

  assign csr_rdata_o   = old_val;
  assign csr_illegal_o = csr_en_i & (~implemented | (csr_we_i & csr_is_ro(csr_addr_i)));
  assign wr_en         = csr_en_i & csr_we_i & ~csr_illegal_o;
  // Trap entry and mret own mstatus/mepc/mcause in their cycle; software writes there are lost.
  assign trap_block    = trap_i | mret_i;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (wr_en) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        CSR_MTVEC:    mtvec_d    = wr_val & ~32'h3;
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = wr_val & ~32'h3;
        CSR_MCAUSE:   mcause_d   = wr_val;
        default: ;
      endcase
    end
    if (trap_block) begin
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
    end
    if (trap_i) begin
      mepc_d   = trap_pc_i & ~32'h3;
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  kamus_csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .we_lo_i (wr_en && (csr_addr_i == CSR_MCYCLE)),
    .we_hi_i (wr_en && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (wr_val),
    .count_o (mcycle)
  );

  kamus_csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (retire_i),
    .we_lo_i (wr_en && (csr_addr_i == CSR_MINSTRET)),
    .we_hi_i (wr_en && (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (wr_val),
    .count_o (minstret)
  );

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_kamus_csr.sv
// Self-checking bench for kamus_csr: directed vector table, hand-written trap/counter/reset
// sequences, then randomized traffic compared against an architectural model.
module tb_kamus_csr;
  import kamus_pkg::*;

  localparam logic [31:0] HART      = 32'hA5A5_0001;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0103;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  kamus_csr_if bus ();
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o;

  kamus_csr #(.HART_ID(HART), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_en_i     (bus.csr_en),
    .csr_addr_i   (bus.csr_addr),
    .csr_op_i     (bus.csr_op),
    .csr_we_i     (bus.csr_we),
    .csr_wdata_i  (bus.csr_wdata),
    .csr_rdata_o  (bus.csr_rdata),
    .csr_illegal_o(bus.csr_illegal),
    .retire_i     (bus.retire),
    .trap_i       (bus.trap),
    .trap_cause_i (bus.trap_cause),
    .trap_pc_i    (bus.trap_pc),
    .mret_i       (bus.mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[$];

  // Architectural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.csr_en = 1'b0; bus.csr_addr = '0; bus.csr_op = '0; bus.csr_we = 1'b0;
    bus.csr_wdata = '0; bus.retire = 1'b0; bus.trap = 1'b0; bus.mret = 1'b0;
    bus.trap_cause = '0; bus.trap_pc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [11:0] a, logic [1:0] op, logic we, logic [31:0] d);
    bus.csr_en = 1'b1; bus.csr_addr = a; bus.csr_op = op; bus.csr_we = we; bus.csr_wdata = d;
  endtask

  task automatic expect_rd(string nm, logic [11:0] a, logic [31:0] exp);
    drive(a, CSR_S, 1'b0, 32'h0);
    #1;
    check(nm, bus.csr_rdata, exp);
    check({nm, "/ill"}, {31'b0, bus.csr_illegal}, 32'd0);
    $display("[TB] read %-14s addr=%03h data=%08h", nm, a, bus.csr_rdata);
    bus.csr_en = 1'b0;
  endtask

  task automatic write_tick(logic [11:0] a, logic [1:0] op, logic [31:0] d);
    drive(a, op, 1'b1, d);
    $display("[TB] write addr=%03h op=%0d data=%08h", a, op, d);
    tick();
    bus.csr_en = 1'b0; bus.csr_we = 1'b0;
  endtask

  function automatic logic m_impl(logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_ill();
    logic ro;
    ro = (bus.csr_addr == 12'h301) || (bus.csr_addr == 12'hF14);
    return bus.csr_en && (!m_impl(bus.csr_addr) || (bus.csr_we && ro));
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mtvec = MTVEC_RST & ~32'h3;
    m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_cyc = '0; m_ins = '0;
  endtask

  task automatic model_step();
    logic [31:0] old, nv, wd;
    logic        wr, blk, mie0, mpie0;
    logic [63:0] cyc_n, ins_n;
    logic [11:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    a = bus.csr_addr; wd = bus.csr_wdata;
    mie0 = m_mie; mpie0 = m_mpie;
    old = m_read(a);
    wr = bus.csr_en && bus.csr_we && !m_ill();
    if (bus.csr_op == 2'd0) nv = wd;
    else if (bus.csr_op == 2'd1) nv = old | wd;
    else nv = old & ~wd;
    blk = bus.trap || bus.mret;
    cyc_n = m_cyc + 64'd1;
    ins_n = bus.retire ? m_ins + 64'd1 : m_ins;
    if (wr) begin
      case (a)
        12'h300: if (!blk) begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: if (!blk) m_mepc = nv & ~32'h3;
        12'h342: if (!blk) m_mcause = nv;
        12'hB00: cyc_n = {m_cyc[63:32], nv};
        12'hB80: cyc_n = {nv, m_cyc[31:0]};
        12'hB02: ins_n = {m_ins[63:32], nv};
        12'hB82: ins_n = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
    if (bus.trap) begin
      m_mepc = bus.trap_pc & ~32'h3; m_mcause = bus.trap_cause; m_mpie = mie0; m_mie = 1'b0;
    end else if (bus.mret) begin
      m_mie = mpie0; m_mpie = 1'b1;
    end
  endtask

  logic [11:0] rnd_addrs[14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h344, 12'h000};

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    check("rst mie_o", {31'b0, mie_o}, 32'd0);
    check("rst mtvec_o", mtvec_o, 32'h8000_0100);
    check("rst mepc_o", mepc_o, 32'd0);
    check("rst illegal", {31'b0, bus.csr_illegal}, 32'd0);

    vecs.push_back('{12'hF14, CSR_S, 1'b0, 32'h0,         HART,          1'b0});
    vecs.push_back('{12'h301, CSR_S, 1'b0, 32'h0,         32'h4000_0100, 1'b0});
    vecs.push_back('{12'h301, CSR_W, 1'b1, 32'hFFFF_FFFF, 32'h4000_0100, 1'b1});
    vecs.push_back('{12'h301, CSR_S, 1'b0, 32'h0,         32'h4000_0100, 1'b0});
    vecs.push_back('{12'hF14, CSR_S, 1'b1, 32'h1,         HART,          1'b1});
    vecs.push_back('{12'h340, CSR_W, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{12'h340, CSR_S, 1'b1, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{12'h340, CSR_C, 1'b1, 32'hFFFF_0000, 32'hDEAD_BEFF, 1'b0});
    vecs.push_back('{12'h340, CSR_S, 1'b0, 32'h0,         32'h0000_BEFF, 1'b0});
    vecs.push_back('{12'h7C0, CSR_S, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{12'h7C0, CSR_W, 1'b1, 32'h1234,      32'h0,         1'b1});
    vecs.push_back('{12'h344, CSR_S, 1'b0, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{12'h305, CSR_W, 1'b1, 32'h1234_5677, 32'h8000_0100, 1'b0});
    vecs.push_back('{12'h305, CSR_S, 1'b0, 32'h0,         32'h1234_5674, 1'b0});
    vecs.push_back('{12'h341, CSR_W, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{12'h341, CSR_S, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{12'h342, CSR_W, 1'b1, 32'h8000_0007, 32'h0,         1'b0});
    vecs.push_back('{12'h342, CSR_S, 1'b0, 32'h0,         32'h8000_0007, 1'b0});
    vecs.push_back('{12'h300, CSR_W, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{12'h300, CSR_C, 1'b1, 32'h0000_0008, 32'h0000_0088, 1'b0});
    vecs.push_back('{12'h300, CSR_S, 1'b0, 32'h0,         32'h0000_0080, 1'b0});
    vecs.push_back('{12'h300, CSR_C, 1'b1, 32'hFFFF_FFFF, 32'h0000_0080, 1'b0});
    vecs.push_back('{12'h300, CSR_S, 1'b0, 32'h0,         32'h0,         1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].op, vecs[i].we, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d rdata", i), bus.csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d illegal", i), {31'b0, bus.csr_illegal}, {31'b0, vecs[i].exp_ill});
      $display("[TB] vec%0d addr=%03h op=%0d we=%0d wdata=%08h rdata=%08h ill=%0d", i,
               vecs[i].addr, vecs[i].op, vecs[i].we, vecs[i].wdata, bus.csr_rdata, bus.csr_illegal);
      tick();
      idle();
    end

    // mcycle wrap through half-writes
    write_tick(12'hB00, CSR_W, 32'hFFFF_FFFF);
    write_tick(12'hB80, CSR_W, 32'hFFFF_FFFF);
    expect_rd("mcycle all1 lo", 12'hB00, 32'hFFFF_FFFF);
    expect_rd("mcycle all1 hi", 12'hB80, 32'hFFFF_FFFF);
    tick();
    expect_rd("mcycle wrap lo", 12'hB00, 32'h0);
    expect_rd("mcycle wrap hi", 12'hB80, 32'h0);
    tick();
    expect_rd("mcycle +1", 12'hB00, 32'h1);

    // minstret: write suppresses the retire increment
    bus.retire = 1'b1;
    write_tick(12'hB02, CSR_W, 32'h5);
    bus.retire = 1'b0;
    expect_rd("minstret wr", 12'hB02, 32'h5);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    expect_rd("minstret inc", 12'hB02, 32'h6);
    bus.retire = 1'b1;
    write_tick(12'hB82, CSR_W, 32'h7);
    bus.retire = 1'b0;
    expect_rd("minstret lo kept", 12'hB02, 32'h6);
    expect_rd("minstreth wr", 12'hB82, 32'h7);
    tick();
    expect_rd("minstret idle", 12'hB02, 32'h6);
    write_tick(12'hB02, CSR_W, 32'hFFFF_FFFF);
    write_tick(12'hB82, CSR_W, 32'hFFFF_FFFF);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    expect_rd("minstret wrap lo", 12'hB02, 32'h0);
    expect_rd("minstret wrap hi", 12'hB82, 32'h0);

    // Trap entry and mret
    write_tick(12'h300, CSR_W, 32'h8);
    #1 check("mie set", {31'b0, mie_o}, 32'd1);
    bus.trap = 1'b1; bus.trap_pc = 32'h8000_0103; bus.trap_cause = 32'hB;
    $display("[TB] trap pc=%08h cause=%08h", bus.trap_pc, bus.trap_cause);
    tick();
    idle();
    #1 check("trap mepc_o", mepc_o, 32'h8000_0100);
    check("trap mie_o", {31'b0, mie_o}, 32'd0);
    expect_rd("trap mcause", 12'h342, 32'hB);
    expect_rd("trap mstatus", 12'h300, 32'h80);
    bus.mret = 1'b1;
    $display("[TB] mret");
    tick();
    idle();
    expect_rd("mret mstatus", 12'h300, 32'h88);
    check("mret mie_o", {31'b0, mie_o}, 32'd1);

    // Simultaneous trap + mret + CSR writes
    bus.trap = 1'b1; bus.mret = 1'b1; bus.trap_pc = 32'h4000_0006; bus.trap_cause = 32'h8000_000B;
    drive(12'h341, CSR_W, 1'b1, 32'h1234);
    #1 check("collide illegal", {31'b0, bus.csr_illegal}, 32'd0);
    $display("[TB] trap+mret+write mepc");
    tick();
    idle();
    #1 check("collide mepc_o", mepc_o, 32'h4000_0004);
    check("collide mie_o", {31'b0, mie_o}, 32'd0);
    expect_rd("collide mcause", 12'h342, 32'h8000_000B);
    expect_rd("collide mstatus", 12'h300, 32'h80);
    bus.trap = 1'b1; bus.mret = 1'b1; bus.trap_pc = 32'h10;
    write_tick(12'h340, CSR_W, 32'h5555_AAAA);
    idle();
    expect_rd("collide mscratch", 12'h340, 32'h5555_AAAA);
    #1 check("collide2 mepc_o", mepc_o, 32'h10);
    expect_rd("collide2 mstatus", 12'h300, 32'h0);
    bus.mret = 1'b1;
    write_tick(12'h341, CSR_W, 32'h99);
    idle();
    expect_rd("mret drops mepc", 12'h341, 32'h10);
    expect_rd("mret2 mstatus", 12'h300, 32'h80);
    bus.mret = 1'b1;
    write_tick(12'h300, CSR_W, 32'h8);
    idle();
    expect_rd("mret drops mstatus", 12'h300, 32'h88);

    // Reset mid-stream with retire and a write active
    rst = 1'b1; bus.retire = 1'b1;
    write_tick(12'h340, CSR_W, 32'h1111);
    rst = 1'b0;
    idle();
    expect_rd("rst2 mcycle", 12'hB00, 32'h0);
    expect_rd("rst2 mcycleh", 12'hB80, 32'h0);
    expect_rd("rst2 minstret", 12'hB02, 32'h0);
    expect_rd("rst2 minstreth", 12'hB82, 32'h0);
    expect_rd("rst2 mstatus", 12'h300, 32'h0);
    expect_rd("rst2 mtvec", 12'h305, 32'h8000_0100);
    expect_rd("rst2 mscratch", 12'h340, 32'h0);
    expect_rd("rst2 mepc", 12'h341, 32'h0);
    expect_rd("rst2 mcause", 12'h342, 32'h0);
    check("rst2 mie_o", {31'b0, mie_o}, 32'd0);
    check("rst2 mtvec_o", mtvec_o, 32'h8000_0100);
    check("rst2 mepc_o", mepc_o, 32'h0);

    // Randomized traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bus.csr_en     = ($urandom_range(0, 3) != 0);
      bus.csr_addr   = rnd_addrs[$urandom_range(0, 13)];
      bus.csr_op     = 2'($urandom_range(0, 2));
      bus.csr_we     = 1'($urandom_range(0, 1));
      bus.csr_wdata  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.retire     = 1'($urandom_range(0, 1));
      bus.trap       = ($urandom_range(0, 7) == 0);
      bus.mret       = ($urandom_range(0, 7) == 0);
      bus.trap_cause = $urandom;
      bus.trap_pc    = $urandom;
      rst            = ($urandom_range(0, 63) == 0);
      #1;
      if (bus.csr_en) check($sformatf("rnd%0d rdata", n), bus.csr_rdata, m_read(bus.csr_addr));
      check($sformatf("rnd%0d illegal", n), {31'b0, bus.csr_illegal}, {31'b0, m_ill()});
      check($sformatf("rnd%0d mie_o", n), {31'b0, mie_o}, {31'b0, m_mie});
      check($sformatf("rnd%0d mtvec_o", n), mtvec_o, m_mtvec);
      check($sformatf("rnd%0d mepc_o", n), mepc_o, m_mepc);
      $display("[TB] rnd%0d en=%0d addr=%03h op=%0d we=%0d wd=%08h rd=%08h ill=%0d ret=%0d trap=%0d mret=%0d rst=%0d",
               n, bus.csr_en, bus.csr_addr, bus.csr_op, bus.csr_we, bus.csr_wdata, bus.csr_rdata,
               bus.csr_illegal, bus.retire, bus.trap, bus.mret, rst);
      model_step();
      tick();
    end
    rst = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kamus_csr.md
KAMUS_CSR -- requirements
Module: kamus_csr

Interface
REQ-001 SHALL have parameter HART_ID, default 32'h0, value returned by mhartid.
REQ-002 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port csr_en_i  in  1  CSR instruction valid this cycle.
REQ-006 SHALL have port csr_addr_i  in  12  CSR address (csr_t).
REQ-007 SHALL have port csr_op_i  in  2  csr_op_t: CSR_W, CSR_S, CSR_C.
REQ-008 SHALL have port csr_we_i  in  1  write intended (0 for CSRRS/CSRRC with zero source).
REQ-009 SHALL have port csr_wdata_i  in  32  rs1 value or zero-extended uimm.
REQ-010 SHALL have port csr_rdata_o  out  32  combinational old value of addressed CSR.
REQ-011 SHALL have port csr_illegal_o  out  1  unimplemented address, or write to read-only CSR.
REQ-012 SHALL have port retire_i  in  1  one instruction retired this cycle.
REQ-013 SHALL have port trap_i  in  1  trap entry this cycle.
REQ-014 SHALL have port trap_cause_i  in  32  mcause value on trap.
REQ-015 SHALL have port trap_pc_i  in  32  faulting pc.
REQ-016 SHALL have port mret_i  in  1  mret executed this cycle.
REQ-017 SHALL have ports mtvec_o, mepc_o  out  32 each, current register values; mie_o  out  1  mstatus.MIE.

Function
REQ-018 SHALL implement mstatus(0x300, MIE bit3, MPIE bit7, other bits read 0), misa(0x301, RO, 32'h4000_0100), mtvec(0x305), mscratch(0x340), mepc(0x341), mcause(0x342), mcycle/mcycleh(0xB00/0xB80), minstret/minstreth(0xB02/0xB82), mhartid(0xF14, RO).
REQ-019 csr_rdata_o SHALL be the pre-update value, valid same cycle as csr_en_i; 0 when address unimplemented.
REQ-020 Write SHALL occur at the clock edge when csr_en_i & csr_we_i & ~csr_illegal_o: new = wdata (W), old|wdata (S), old&~wdata (C).
REQ-021 csr_illegal_o SHALL assert combinationally when csr_en_i and (address unimplemented, or csr_we_i and address is RO); no state SHALL change.
REQ-022 mepc bits[1:0] and mtvec bits[1:0] SHALL always read 0.
REQ-023 mcycle SHALL be 64-bit, increment every cycle, wrap 2^64-1 -> 0.
REQ-024 minstret SHALL be 64-bit, increment when retire_i, wrap 2^64-1 -> 0.
REQ-025 Counter CSR write SHALL replace only the addressed 32-bit half and suppress that counter's increment in that cycle; the other half SHALL not change.
REQ-026 On trap_i: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, MPIE<=MIE, MIE<=0, at next edge.
REQ-027 On mret_i (no trap_i): MIE<=MPIE, MPIE<=1.
REQ-028 Priority same cycle: trap_i > mret_i > CSR write for mstatus/mepc/mcause; a simultaneous CSR write to those SHALL be dropped; writes to other CSRs SHALL proceed.
REQ-029 retire_i SHALL still count when trap_i is high.

Reset
REQ-030 On rst_i high at an edge: mstatus=0, mtvec=MTVEC_RESET&~3, mscratch=0, mepc=0, mcause=0, mcycle=0, minstret=0; overrides all other events same cycle.
REQ-031 Outputs after reset: mie_o=0, mtvec_o=MTVEC_RESET&~3, mepc_o=0; csr_illegal_o/csr_rdata_o remain combinational.

Structure
REQ-032 csr_t address enum and csr_op_t SHALL live in kamus_pkg, shared with decoder and EX.
REQ-033 SHALL instantiate sub-module kamus_csr_counter64 (64-bit counter, inc enable, lo/hi write enables, 32-bit write data) twice, for mcycle and minstret.

Verification
REQ-034 Reset then read 0xF14, 0x301 -> HART_ID, 32'h4000_0100; write 0x301 -> illegal_o=1, value unchanged.
REQ-035 CSR_W 0x340=0xDEAD_BEEF, CSR_S 0x340 0x0000_00F0 (rdata=DEADBEEF), CSR_C 0x340 0xFFFF_0000 -> reads 0x0000_BEFF.
REQ-036 Write mcycle lo=0xFFFF_FFFF, hi=0xFFFF_FFFF on consecutive cycles -> next cycles read mcycle=0x0 and mcycleh=0x0 (wrap).
REQ-037 MIE=1, trap_i with pc=0x8000_0103, cause=0xB -> mepc=0x8000_0100, mcause=0xB, MIE=0, MPIE=1; mret_i -> MIE=1, MPIE=1.
REQ-038 trap_i, mret_i and CSR_W mepc=0x1234 same cycle -> mepc=trap_pc_i&~3, MIE=0; mscratch write same cycle still lands.
REQ-039 rst_i asserted mid-stream with retire_i and CSR write active -> all registers at reset values next cycle, minstret=0.
